nios_cpu_mul_seq: RTL and testbench

NIOS_CPU_MUL_SEQ -- requirements
Module: nios_cpu_mul_seq

---
 rtl/nios_cpu_mul_pkg.sv | 21 ++
 rtl/nios_cpu_mul_acc.sv | 65 ++++++
 rtl/nios_cpu_mul_seq.sv | 219 +++++++++++++++++++++
 tb/tb_nios_cpu_mul_seq.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/nios_cpu_mul_pkg.sv
// ---------------------------------------------------------------------------
// nios_cpu_mul_pkg
//   Shared constants and types for the sequential multiply front-end.
//   - MUL_DATA_W / MUL_HALF_W : operand width and the half-word slice width
//   - MUL_PASSES              : number of half-word passes for the high word
//   - state_e                 : controller states (also driven on dbg_state)
// ---------------------------------------------------------------------------
package nios_cpu_mul_pkg;

  localparam int MUL_DATA_W = 32;
  localparam int MUL_HALF_W = MUL_DATA_W / 2;
  localparam int MUL_PASSES = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/nios_cpu_mul_acc.sv
// ---------------------------------------------------------------------------
// nios_cpu_mul_acc
//   64-bit shift-add accumulator for the four half-word partial products of
//   an unsigned 32x32 high-word multiply. Only built when
//   NIOS_CPU_MUL_HIGH_EN is defined.
//
//   Ports:
//     clk, reset   : clock, synchronous active-high reset (clears the sum)
//     clear_i      : zero the accumulator (start of a new operation)
//     add_en_i     : add pp_i, weighted by pass_idx_i, this cycle
//     pass_idx_i   : pass of pp_i (0: <<0, 1/2: <<HALF_W, 3: <<DATA_W)
//     pp_i         : partial product from the mult cell
//     sum_hi_o     : upper word of (accumulator + weighted pp_i); this is the
//                    final high word in the cycle the last pass is added
// ---------------------------------------------------------------------------
module nios_cpu_mul_acc
  import nios_cpu_mul_pkg::*;
#(
  parameter int DATA_W = MUL_DATA_W,
  parameter int HALF_W = MUL_HALF_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              add_en_i,
  input  logic [1:0]        pass_idx_i,
  input  logic [DATA_W-1:0] pp_i,
  output logic [DATA_W-1:0] sum_hi_o
);

  logic [2*DATA_W-1:0] acc_q;
  logic [2*DATA_W-1:0] acc_d;
  logic [2*DATA_W-1:0] pp_ext;
  logic [2*DATA_W-1:0] pp_sh;
  logic [2*DATA_W-1:0] sum;

  always_comb begin
    pp_ext = {{DATA_W{1'b0}}, pp_i};
    pp_sh  = pp_ext;
    case (pass_idx_i)
      2'd0:       pp_sh = pp_ext;
      2'd1, 2'd2: pp_sh = pp_ext << HALF_W;
      default:    pp_sh = pp_ext << DATA_W;
    endcase
    sum = acc_q + pp_sh;

    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (add_en_i) begin
      acc_d = sum;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign sum_hi_o = sum[2*DATA_W-1:DATA_W];

endmodule

// File: rtl/nios_cpu_mul_seq.sv
// ---------------------------------------------------------------------------
// nios_cpu_mul_seq
//   Sequential multiply front-end driving an external 1-cycle mult cell.
//   Low mode (mul): one issue cycle, result = low word of src1*src2.
//   High mode (mulxuu): four half-word passes accumulated into 64 bits,
//   result = unsigned high word. High mode exists only when the macro
//   NIOS_CPU_MUL_HIGH_EN is defined; otherwise req_high is ignored.
//
//   Ports:
//     clk, reset                : clock, synchronous active-high reset
//     req_valid/req_ready       : request handshake
//     req_high                  : 0 = low word, 1 = unsigned high word
//     req_src1/req_src2         : operands
//     flush                     : kill; back to IDLE, result dropped
//     M_mul_src1/M_mul_src2     : operands to the mult cell (0 outside ISSUE)
//     M_mul_cell_result         : cell output, valid one clk after operands
//     rsp_valid/rsp_ready       : response handshake
//     rsp_data                  : result
//     dbg_state                 : current controller state (state_e)
//
//   Handshakes: a transfer happens on a rising edge where valid and ready are
//   both 1. req_ready does not depend on req_valid; rsp_valid/rsp_data stay
//   stable until the transfer. flush and reset override both handshakes.
//
//   Latency: accept at cycle T -> rsp_valid at T+3 (low) or T+6 (high).
// ---------------------------------------------------------------------------
module nios_cpu_mul_seq
  import nios_cpu_mul_pkg::*;
#(
  parameter int DATA_W = MUL_DATA_W,
  parameter int HALF_W = MUL_HALF_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_high,
  input  logic [DATA_W-1:0] req_src1,
  input  logic [DATA_W-1:0] req_src2,
  input  logic              flush,
  output logic [DATA_W-1:0] M_mul_src1,
  output logic [DATA_W-1:0] M_mul_src2,
  input  logic [DATA_W-1:0] M_mul_cell_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        dbg_state
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [DATA_W-1:0] mul_src1, mul_src2;

`ifdef NIOS_CPU_MUL_HIGH_EN
  logic              high_q, high_d;
  logic [1:0]        pass_q, pass_d;
  // cap_* tracks the pass whose product arrives from the cell this cycle.
  logic              cap_en_q, cap_en_d;
  logic [1:0]        cap_idx_q, cap_idx_d;
  logic              acc_clear;
  logic [DATA_W-1:0] acc_sum_hi;

  nios_cpu_mul_acc #(
    .DATA_W (DATA_W),
    .HALF_W (HALF_W)
  ) u_acc (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (acc_clear),
    .add_en_i   (cap_en_q),
    .pass_idx_i (cap_idx_q),
    .pp_i       (M_mul_cell_result),
    .sum_hi_o   (acc_sum_hi)
  );
`else
  // Without high-word support req_high and the slice width have no use.
  logic [HALF_W:0] unused_cfg;
  assign unused_cfg = {req_high, {HALF_W{1'b0}}};
`endif

  // -------------------------------------------------------------------------
  // Next-state / datapath control
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    rsp_data_d = rsp_data_q;
`ifdef NIOS_CPU_MUL_HIGH_EN
    high_d     = high_q;
    pass_d     = pass_q;
    cap_en_d   = 1'b0;
    cap_idx_d  = cap_idx_q;
    acc_clear  = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          a_d     = req_src1;
          b_d     = req_src2;
          state_d = ST_ISSUE;
`ifdef NIOS_CPU_MUL_HIGH_EN
          high_d    = req_high;
          pass_d    = 2'd0;
          acc_clear = 1'b1;
`endif
        end
      end

      ST_ISSUE: begin
`ifdef NIOS_CPU_MUL_HIGH_EN
        cap_en_d  = high_q;
        cap_idx_d = pass_q;
        if (high_q && (pass_q != 2'(MUL_PASSES - 1))) begin
          pass_d = pass_q + 2'd1;
        end else begin
          state_d = ST_DRAIN;
        end
`else
        state_d = ST_DRAIN;
`endif
      end

      ST_DRAIN: begin
        // The last cell product arrives this cycle; in high mode it is folded
        // into the accumulator sum combinationally so the word is final here.
`ifdef NIOS_CPU_MUL_HIGH_EN
        rsp_data_d = high_q ? acc_sum_hi : M_mul_cell_result;
`else
        rsp_data_d = M_mul_cell_result;
`endif
        state_d = ST_DONE;
      end

      ST_DONE: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // flush wins over everything except reset.
    if (flush) begin
      state_d    = ST_IDLE;
      rsp_data_d = '0;
`ifdef NIOS_CPU_MUL_HIGH_EN
      cap_en_d   = 1'b0;
      acc_clear  = 1'b0;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Mult cell operands: full words in low mode, zero-extended half-word
  // slices in high mode (pass bit 0 picks a's half, bit 1 picks b's half).
  // -------------------------------------------------------------------------
  always_comb begin
    mul_src1 = '0;
    mul_src2 = '0;
    if (state_q == ST_ISSUE) begin
`ifdef NIOS_CPU_MUL_HIGH_EN
      if (high_q) begin
        mul_src1 = {{(DATA_W-HALF_W){1'b0}},
                    pass_q[0] ? a_q[DATA_W-1:HALF_W] : a_q[HALF_W-1:0]};
        mul_src2 = {{(DATA_W-HALF_W){1'b0}},
                    pass_q[1] ? b_q[DATA_W-1:HALF_W] : b_q[HALF_W-1:0]};
      end else begin
        mul_src1 = a_q;
        mul_src2 = b_q;
      end
`else
      mul_src1 = a_q;
      mul_src2 = b_q;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      rsp_data_q <= '0;
`ifdef NIOS_CPU_MUL_HIGH_EN
      high_q     <= 1'b0;
      pass_q     <= 2'd0;
      cap_en_q   <= 1'b0;
      cap_idx_q  <= 2'd0;
`endif
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rsp_data_q <= rsp_data_d;
`ifdef NIOS_CPU_MUL_HIGH_EN
      high_q     <= high_d;
      pass_q     <= pass_d;
      cap_en_q   <= cap_en_d;
      cap_idx_q  <= cap_idx_d;
`endif
    end
  end

  assign req_ready  = (state_q == ST_IDLE) && !flush;
  assign rsp_valid  = (state_q == ST_DONE);
  assign rsp_data   = rsp_data_q;
  assign M_mul_src1 = mul_src1;
  assign M_mul_src2 = mul_src2;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_nios_cpu_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_nios_cpu_mul_seq
//   Directed bench for nios_cpu_mul_seq with a behavioural 1-cycle mult cell.
//   Expected results are hand-computed; the high-mode entries depend on
//   whether NIOS_CPU_MUL_HIGH_EN is defined for the build.
// ---------------------------------------------------------------------------
module tb_nios_cpu_mul_seq;
  import nios_cpu_mul_pkg::*;

`ifdef NIOS_CPU_MUL_HIGH_EN
  localparam bit HIGH_EN = 1'b1;
`else
  localparam bit HIGH_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_high = 1'b0;
  logic [31:0] req_src1 = '0;
  logic [31:0] req_src2 = '0;
  logic        flush = 1'b0;
  logic        rsp_ready = 1'b0;
  logic        req_ready;
  logic [31:0] M_mul_src1, M_mul_src2;
  logic [31:0] cell_q = '0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  // Behavioural mult cell: low 32 bits of the product, one clock later.
  always @(posedge clk) cell_q <= M_mul_src1 * M_mul_src2;

  nios_cpu_mul_seq dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_high          (req_high),
    .req_src1          (req_src1),
    .req_src2          (req_src2),
    .flush             (flush),
    .M_mul_src1        (M_mul_src1),
    .M_mul_src2        (M_mul_src2),
    .M_mul_cell_result (cell_q),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_data          (rsp_data),
    .dbg_state         (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks (called at a negedge, DUT in IDLE) ----------------
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic high, input logic [31:0] exp_data,
                        input int exp_lat, input int stall);
    int lat;
    logic [31:0] exp_s1, exp_s2;
    exp_s1 = (HIGH_EN && high) ? {16'h0, a[15:0]} : a;
    exp_s2 = (HIGH_EN && high) ? {16'h0, b[15:0]} : b;
    check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_src1  = a;
    req_src2  = b;
    req_high  = high;
    exp_q.push_back(exp_data);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    check_eq({tag, "_issue_src1"}, M_mul_src1, exp_s1);
    check_eq({tag, "_issue_src2"}, M_mul_src2, exp_s2);
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_data"}, rsp_data, exp_q.pop_front());
    check_eq({tag, "_src_done"}, M_mul_src1 | M_mul_src2, 32'd0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check_eq({tag, "_stall_valid"}, 32'(rsp_valid), 32'd1);
      check_eq({tag, "_stall_data"}, rsp_data, exp_data);
      check_eq({tag, "_stall_req_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    check_eq({tag, "_req_ready_handoff"}, 32'(req_ready), 32'd0);
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq({tag, "_valid_after"}, 32'(rsp_valid), 32'd0);
    check_eq({tag, "_state_after"}, 32'(dbg_state), 32'(ST_IDLE));
    check_eq({tag, "_req_ready_after"}, 32'(req_ready), 32'd1);
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check_eq({tag, "_no_rsp"}, 32'(seen), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_data", rsp_data, 32'd0);
    check_eq("rst_src", M_mul_src1 | M_mul_src2, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // Low mode
    run_op("low_3x5", 32'd3, 32'd5, 1'b0, 32'h0000000F, 3, 0);
    run_op("low_ffxff", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000001, 3, 0);

    // High mode (falls back to low mode when high-word support is absent)
    run_op("high_ffxff", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1,
           HIGH_EN ? 32'hFFFFFFFE : 32'h00000001, HIGH_EN ? 6 : 3, 0);
    run_op("high_2p16sq", 32'h00010000, 32'h00010000, 1'b1,
           HIGH_EN ? 32'h00000001 : 32'h00000000, HIGH_EN ? 6 : 3, 0);
    run_op("high_mixed", 32'h00020003, 32'h00050007, 1'b1,
           HIGH_EN ? 32'h0000000A : 32'h001D0015, HIGH_EN ? 6 : 3, 0);

    // Backpressure: rsp_ready held low for 5 cycles
    run_op("stall", 32'h00001234, 32'h00000010, 1'b0, 32'h00012340, 3, 5);

    // Flush at accept+2 of a high-mode op
    req_valid = 1'b1; req_src1 = 32'hFFFFFFFF; req_src2 = 32'hFFFFFFFF; req_high = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_eq("flush_valid", 32'(rsp_valid), 32'd0);
    check_eq("flush_state", 32'(dbg_state), 32'(ST_IDLE));
    check_eq("flush_src", M_mul_src1 | M_mul_src2, 32'd0);
    expect_quiet("flush", 8);
    run_op("flush_next_2x7", 32'd2, 32'd7, 1'b0, 32'h0000000E, 3, 0);

    // Reset pulse during DRAIN (rsp_data still holds 0x0E from the last op)
    req_valid = 1'b1; req_src1 = 32'd3; req_src2 = 32'd5; req_high = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check_eq("rstmid_in_drain", 32'(dbg_state), 32'(ST_DRAIN));
    reset = 1'b1;
    @(negedge clk);
    check_eq("rstmid_valid", 32'(rsp_valid), 32'd0);
    check_eq("rstmid_data", rsp_data, 32'd0);
    check_eq("rstmid_src", M_mul_src1 | M_mul_src2, 32'd0);
    check_eq("rstmid_state", 32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b0;
    check_eq("rstmid_req_ready", 32'(req_ready), 32'd1);
    expect_quiet("rstmid", 6);

    // flush together with req_valid in IDLE: not accepted
    req_valid = 1'b1; req_src1 = 32'd9; req_src2 = 32'd9; req_high = 1'b0;
    flush = 1'b1;
    #1;
    check_eq("flushreq_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    flush = 1'b0;
    check_eq("flushreq_state", 32'(dbg_state), 32'(ST_IDLE));
    check_eq("flushreq_src", M_mul_src1 | M_mul_src2, 32'd0);
    expect_quiet("flushreq", 6);
    run_op("post_6x7", 32'd6, 32'd7, 1'b0, 32'h0000002A, 3, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
